// File: rtl/proc_trace_buffer_pkg.sv
// Shared types for the processor commit-trace capture buffer.
//   trace_state_e : capture session phase (IDLE / WAIT_TRIG / CAPTURE / DONE)
//   trace_rec_t   : one commit record {addr, inst, data} at the default field width
//   cnt_w()       : width needed to hold a record count from 0 up to DEPTH
package proc_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } trace_state_e;

  localparam int REC_FIELD_W = 32;

  typedef struct packed {
    logic [REC_FIELD_W-1:0] addr;
    logic [REC_FIELD_W-1:0] inst;
    logic [REC_FIELD_W-1:0] data;
  } trace_rec_t;

  // A count must represent DEPTH itself (buffer full), hence DEPTH+1 values.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/proc_trace_buffer_if.sv
// Bus bundle between a trace source/consumer and proc_trace_buffer.
//   trace_*  : commit record stream from the processor
//   cfg_*    : session configuration, sampled when arm is accepted
//   arm/stop : single-cycle session control pulses
//   rd_*     : valid/ready drain port for captured records
//   count/overflow/busy : buffer status
// master = harness side (drives trace, cfg, control, rd_rdy)
// slave  = buffer side
interface proc_trace_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
);
  localparam int CNT_W = proc_trace_pkg::cnt_w(DEPTH);

  logic              trace_val;
  logic [DATA_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_inst;
  logic [DATA_W-1:0] trace_data;
  logic              cfg_wrap;
  logic              cfg_trig_en;
  logic [DATA_W-1:0] cfg_trig_addr;
  logic              arm;
  logic              stop;
  logic              rd_val;
  logic              rd_rdy;
  logic [DATA_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_inst;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              busy;

  modport master (
    output trace_val, trace_addr, trace_inst, trace_data,
    output cfg_wrap, cfg_trig_en, cfg_trig_addr,
    output arm, stop, rd_rdy,
    input  rd_val, rd_addr, rd_inst, rd_data,
    input  count, overflow, busy
  );

  modport slave (
    input  trace_val, trace_addr, trace_inst, trace_data,
    input  cfg_wrap, cfg_trig_en, cfg_trig_addr,
    input  arm, stop, rd_rdy,
    output rd_val, rd_addr, rd_inst, rd_data,
    output count, overflow, busy
  );

endinterface

// File: rtl/proc_trace_buffer_ram.sv
// trace_ram: record storage for proc_trace_buffer.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write slot
//   wdata_i : packed record {addr, inst, data}
//   raddr_i : read slot
//   rdata_o : record at raddr_i, combinational
// Contents are not reset; the buffer's count decides which slots are meaningful.
module trace_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 96,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/proc_trace_buffer.sv
// proc_trace_buffer: captures processor commit records into a DEPTH-entry
// circular store and drains them through a valid/ready port once the capture
// session has finished.
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : proc_trace_buffer_if.slave (trace input, cfg, arm/stop, rd port, status)
// Session flow: arm -> (WAIT_TRIG ->) CAPTURE -> DONE, drain in DONE, re-arm.
module proc_trace_buffer
  import proc_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  proc_trace_buffer_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int REC_W = 3 * DATA_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  trace_state_e      state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              wrap_q, wrap_d;
  logic [DATA_W-1:0] trig_addr_q, trig_addr_d;

  logic              arm_ok;
  logic              trig_hit;
  logic              wr_en;
  logic              full;
  logic              pop;
  logic [REC_W-1:0]  rd_rec;

  // Event decode. A write can only happen in WAIT_TRIG or CAPTURE and a pop
  // only in DONE, so the two never coincide.
  always_comb begin
    arm_ok   = bus.arm && ((state_q == IDLE) || (state_q == DONE));
    trig_hit = (state_q == WAIT_TRIG) && bus.trace_val &&
               (bus.trace_addr == trig_addr_q);
    wr_en    = trig_hit || ((state_q == CAPTURE) && bus.trace_val);
    full     = (count_q == FULL_CNT);
    pop      = (state_q == DONE) && (count_q != '0) && bus.rd_rdy;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. In stop mode the write that fills the last slot ends the
  // session; stop wins over the trigger so a late stop still terminates.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.arm) begin
          state_d = bus.cfg_trig_en ? WAIT_TRIG : CAPTURE;
        end
      end
      WAIT_TRIG: begin
        if (bus.stop) begin
          state_d = DONE;
        end else if (trig_hit) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.stop || (wr_en && !wrap_q && (count_q == LAST_CNT))) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer, count and session-config registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      wrap_q      <= 1'b0;
      trig_addr_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      wrap_q      <= wrap_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  // A write while full can only occur in wrap mode (stop mode has already
  // left CAPTURE): it overwrites the oldest slot, so the read pointer moves
  // past it and the count stays at DEPTH.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    wrap_d      = wrap_q;
    trig_addr_d = trig_addr_q;
    if (arm_ok) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      wrap_d      = bus.cfg_wrap;
      trig_addr_d = bus.cfg_trig_addr;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (full) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end
  end

  trace_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (REC_W),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.trace_addr, bus.trace_inst, bus.trace_data}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_rec)
  );

  // FSM outputs and status. Records are offered only once the session is DONE.
  always_comb begin
    bus.busy     = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
    bus.rd_val   = (state_q == DONE) && (count_q != '0);
    bus.rd_addr  = rd_rec[REC_W-1 -: DATA_W];
    bus.rd_inst  = rd_rec[2*DATA_W-1 -: DATA_W];
    bus.rd_data  = rd_rec[DATA_W-1:0];
    bus.count    = count_q;
    bus.overflow = overflow_q;
  end

endmodule

// File: doc/proc_trace_buffer.md
Name: proc_trace_buffer

Overview:
- Parametrised capture buffer for the processor commit trace (trace_val/addr/inst/data) emitted by the ProcFL/TinyRV1 processors.
- Records committed instructions into a DEPTH-entry circular store, with an optional start trigger on a PC match and stop-on-full or wrap capture modes.
- Captured records are drained through a valid/ready read port.
- Sits beside the processor in test harnesses and on-board debug, replacing ad-hoc per-cycle trace polling.

Parameters:
- DEPTH, 16, number of trace records stored; power of two, at least 2.
- DATA_W, 32, width of the addr, inst and data fields.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- trace_val  in  1  a commit record is present this cycle.
- trace_addr  in  DATA_W  PC of the committed instruction.
- trace_inst  in  DATA_W  instruction word.
- trace_data  in  DATA_W  writeback data; X is permitted and is stored as-is.
- cfg_wrap  in  1  0 = stop when full; 1 = overwrite the oldest record.
- cfg_trig_en  in  1  1 = wait for a PC match before capturing.
- cfg_trig_addr  in  DATA_W  trigger PC.
- arm  in  1  single-cycle pulse that starts a capture session.
- stop  in  1  single-cycle pulse that ends capture.
- rd_val  out  1  a record is available on rd_*.
- rd_rdy  in  1  consumer accepts the record.
- rd_addr, rd_inst, rd_data  out  DATA_W  oldest unread record.
- count  out  $clog2(DEPTH+1)  number of records held.
- overflow  out  1  at least one record was overwritten (wrap mode).
- busy  out  1  state is WAIT_TRIG or CAPTURE.

Behaviour:
- Reset, asynchronous: state = IDLE, write and read pointers = 0, count = 0, overflow = 0, busy = 0, rd_val = 0.
- States are IDLE, WAIT_TRIG, CAPTURE and DONE.
- arm applies in IDLE or DONE:
  - Clears the pointers, count and overflow.
  - Next state is WAIT_TRIG if cfg_trig_en = 1, otherwise CAPTURE.
  - arm is ignored in WAIT_TRIG and CAPTURE.
- cfg_* inputs are sampled on the cycle arm is accepted and held internally for the whole session.
- WAIT_TRIG:
  - trace_val=1 with trace_addr == trig_addr writes that record in the same cycle (count becomes 1) and moves to CAPTURE.
  - Non-matching records are dropped.
  - stop moves to DONE with count = 0.
- CAPTURE:
  - Each trace_val=1 cycle writes one record at the write pointer; the pointer wraps modulo DEPTH.
  - Stop mode (cfg_wrap=0): the write that makes count == DEPTH also transitions to DONE. Records arriving in DONE are dropped.
  - Wrap mode (cfg_wrap=1), when already full: the write overwrites the oldest record, the read pointer advances by 1, count stays DEPTH, and overflow is set sticky.
  - stop moves to DONE. If stop and trace_val coincide, the record is written first.
- Write latency: the record is visible on rd_* the cycle after the write, once in DONE.
- Readout only in DONE:
  - rd_val = (count != 0); rd_* show the record at the read pointer (combinational from the storage array).
  - When rd_val && rd_rdy, the read pointer increments and count decrements.
  - Emptying the buffer leaves the state in DONE.
  - rd_val = 0 in every other state; draining during capture is not supported.
- arm in DONE with count != 0 discards the unread records.
- busy = (state == WAIT_TRIG || state == CAPTURE).
- overflow holds until the next arm or reset.
- Reset mid-capture or mid-drain discards everything with no partial output.

Decomposition:
- Shared package proc_trace_pkg holds:
  - the state enum (IDLE/WAIT_TRIG/CAPTURE/DONE);
  - the packed record struct {addr, inst, data};
  - the count width function.
- One sub-module, trace_ram: DEPTH × 3·DATA_W storage with synchronous write and combinational read.
- The pointer/count/FSM logic stays in proc_trace_buffer.

Test Plan:
1. Reset mid-operation: arm, write 3 records, assert rst -> count=0, rd_val=0, state IDLE, busy=0 immediately (asynchronous).
2. Stop mode, no trigger, DEPTH=4: arm, feed PCs 0x200,0x204,0x208,0x20c,0x210 -> DONE after the 4th write; drain yields 0x200..0x20c in order; 0x210 is dropped; overflow=0.
3. Wrap mode, DEPTH=4: feed 6 records at PCs 0x200..0x214, then stop -> count=4, overflow=1; drain yields 0x208,0x20c,0x210,0x214.
4. Trigger: cfg_trig_addr=0x208; feed 0x200,0x204,0x208,0x20c, then stop -> 2 records, 0x208 then 0x20c. A data field of X is read back as X.
5. Handshake: in DONE with 3 records, hold rd_rdy=0 for 3 cycles -> rd_* stable and count=3; then toggle rd_rdy 1,0,1,1 -> exactly 3 pops, then rd_val=0.
6. Coincident events: stop and trace_val in the same cycle -> the record is captured. arm while in CAPTURE -> ignored. arm in DONE with 2 unread records -> count=0 and a new session starts.
